// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode, ALU-control and immediate-source definitions for the decode stage
package decode_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_src_e;

    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       memwrite;
        logic       resultsrc;
        logic       branch;
        logic [2:0] alucontrol;
        imm_src_e   immsrc;
    } ctrl_t;

    function automatic logic [31:0] imm_ext32(input logic [31:0] instr, input imm_src_e src);
        logic [31:0] v;
        case (src)
            IMM_I:   v = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - combinational opcode/funct decode into main control bits and ALU control
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output ctrl_t      o_ctrl
);

    logic [2:0] w_alu_funct;
    logic       w_is_r;

    assign w_is_r = (i_opcode == OP_R);

    // Only register-register ops may subtract; I-ALU funct7 bits are immediate bits.
    always_comb begin
        w_alu_funct = ALU_ADD;
        case (i_funct3)
            3'b000:  w_alu_funct = (w_is_r && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_funct = ALU_SLT;
            3'b110:  w_alu_funct = ALU_OR;
            3'b111:  w_alu_funct = ALU_AND;
            default: w_alu_funct = ALU_ADD;
        endcase
    end

    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OP_LW: begin
                o_ctrl.regwrite   = 1'b1;
                o_ctrl.alusrc     = 1'b1;
                o_ctrl.resultsrc  = 1'b1;
                o_ctrl.alucontrol = ALU_ADD;
                o_ctrl.immsrc     = IMM_I;
            end
            OP_SW: begin
                o_ctrl.alusrc     = 1'b1;
                o_ctrl.memwrite   = 1'b1;
                o_ctrl.alucontrol = ALU_ADD;
                o_ctrl.immsrc     = IMM_S;
            end
            OP_R: begin
                o_ctrl.regwrite   = 1'b1;
                o_ctrl.alucontrol = w_alu_funct;
                o_ctrl.immsrc     = IMM_NONE;
            end
            OP_I: begin
                o_ctrl.regwrite   = 1'b1;
                o_ctrl.alusrc     = 1'b1;
                o_ctrl.alucontrol = w_alu_funct;
                o_ctrl.immsrc     = IMM_I;
            end
            OP_BEQ: begin
                o_ctrl.branch     = 1'b1;
                o_ctrl.alucontrol = ALU_SUB;
                o_ctrl.immsrc     = IMM_B;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage_hs.sv
// rtl/decode_stage_hs.sv - ID stage with register file, load-use stall and ID/EX handshake register (RF_BYPASS_EN: same-cycle writeback bypass)
module decode_stage_hs
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int CW   = 16,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            valid_o,
    output logic            regwrite_o,
    output logic            alusrc_o,
    output logic            memwrite_o,
    output logic            resultsrc_o,
    output logic            branch_o,
    output logic [2:0]      alucontrol_o,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [AW-1:0]   rs1_o,
    output logic [AW-1:0]   rs2_o,
    output logic [AW-1:0]   rd_o,
    output logic [CW-1:0]   hazard_cnt_o
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            alusrc;
        logic            memwrite;
        logic            resultsrc;
        logic            branch;
        logic [2:0]      alucontrol;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
    } idex_t;

    logic [XLEN-1:0] r_rf [NREG];
    idex_t           r_idex;
    logic [CW-1:0]   r_hcnt;

    ctrl_t           w_ctrl;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_imm;
    logic            w_load_use;
    logic            w_xfer;
    idex_t           w_next;

    assign w_rs1 = instr_i[15 +: AW];
    assign w_rs2 = instr_i[20 +: AW];
    assign w_rd  = instr_i[7 +: AW];

    decode_ctrl u_ctrl (
        .i_opcode   (instr_i[6:0]),
        .i_funct3   (instr_i[14:12]),
        .i_funct7b5 (instr_i[30]),
        .o_ctrl     (w_ctrl)
    );

    assign w_imm = XLEN'($signed(imm_ext32(instr_i, w_ctrl.immsrc)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (wb_we_i && (wb_rd_i != '0)) begin
            r_rf[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_rs1 != '0) w_rd1 = r_rf[w_rs1];
        if (w_rs2 != '0) w_rd2 = r_rf[w_rs2];
`ifdef RF_BYPASS_EN
        if (wb_we_i && (w_rs1 != '0) && (wb_rd_i == w_rs1)) w_rd1 = wb_data_i;
        if (wb_we_i && (w_rs2 != '0) && (wb_rd_i == w_rs2)) w_rd2 = wb_data_i;
`endif
    end

    assign w_load_use = valid_i && r_idex.valid && r_idex.resultsrc && (r_idex.rd != '0)
                        && ((r_idex.rd == w_rs1) || (r_idex.rd == w_rs2));
    assign ready_o    = (!r_idex.valid || ex_ready_i) && !w_load_use && !flush_i;
    assign w_xfer     = valid_i && ready_o;

    always_comb begin
        w_next            = '0;
        w_next.valid      = 1'b1;
        w_next.regwrite   = w_ctrl.regwrite;
        w_next.alusrc     = w_ctrl.alusrc;
        w_next.memwrite   = w_ctrl.memwrite;
        w_next.resultsrc  = w_ctrl.resultsrc;
        w_next.branch     = w_ctrl.branch;
        w_next.alucontrol = w_ctrl.alucontrol;
        w_next.rd1        = w_rd1;
        w_next.rd2        = w_rd2;
        w_next.imm        = w_imm;
        w_next.pc         = pc_i;
        w_next.pc4        = pc4_i;
        w_next.rs1        = w_rs1;
        w_next.rs2        = w_rs2;
        w_next.rd         = w_rd;
    end

    // Flush outranks everything; a stalled, unconsumed entry is held only while EX refuses it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idex <= '0;
            r_hcnt <= '0;
        end else if (flush_i) begin
            r_idex <= '0;
        end else if (w_xfer) begin
            r_idex <= w_next;
        end else if (w_load_use && ex_ready_i) begin
            r_idex <= '0;
            if (r_hcnt != '1) r_hcnt <= r_hcnt + 1'b1;
        end else if (!(r_idex.valid && !ex_ready_i)) begin
            r_idex <= '0;
        end
    end

    assign valid_o      = r_idex.valid;
    assign regwrite_o   = r_idex.regwrite;
    assign alusrc_o     = r_idex.alusrc;
    assign memwrite_o   = r_idex.memwrite;
    assign resultsrc_o  = r_idex.resultsrc;
    assign branch_o     = r_idex.branch;
    assign alucontrol_o = r_idex.alucontrol;
    assign rd1_o        = r_idex.rd1;
    assign rd2_o        = r_idex.rd2;
    assign imm_o        = r_idex.imm;
    assign pc_o         = r_idex.pc;
    assign pc4_o        = r_idex.pc4;
    assign rs1_o        = r_idex.rs1;
    assign rs2_o        = r_idex.rs2;
    assign rd_o         = r_idex.rd;
    assign hazard_cnt_o = r_hcnt;

endmodule

// File: tb/tb_decode_stage_hs.sv
// tb/tb_decode_stage_hs.sv - directed self-checking bench for decode_stage_hs
module tb_decode_stage_hs;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int CW   = 4;
    localparam int AW   = 5;

    localparam logic [31:0] I_ADDI_6_5_4  = 32'h00428313;
    localparam logic [31:0] I_LW_7_0_1    = 32'h0000A383;
    localparam logic [31:0] I_ADD_8_7_2   = 32'h00238433;
    localparam logic [31:0] I_SUB_9_3_0   = 32'h400184B3;
    localparam logic [31:0] I_SW_5_8_1    = 32'h0050A423;
    localparam logic [31:0] I_BEQ_M8      = 32'hFE000CE3;
    localparam logic [31:0] I_ADDI_10_0_0 = 32'h00000513;
    localparam logic [31:0] I_LW_7_0_7    = 32'h0003A383;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic            ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i, pc4_i;
    logic            wb_we_i;
    logic [AW-1:0]   wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            flush_i;
    logic            ex_ready_i;
    logic            valid_o, regwrite_o, alusrc_o, memwrite_o, resultsrc_o, branch_o;
    logic [2:0]      alucontrol_o;
    logic [XLEN-1:0] rd1_o, rd2_o, imm_o, pc_o, pc4_o;
    logic [AW-1:0]   rs1_o, rs2_o, rd_o;
    logic [CW-1:0]   hazard_cnt_o;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] held_rd1;

    decode_stage_hs #(.XLEN(XLEN), .NREG(NREG), .CW(CW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i),
        .pc_i(pc_i), .pc4_i(pc4_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i), .valid_o(valid_o), .regwrite_o(regwrite_o),
        .alusrc_o(alusrc_o), .memwrite_o(memwrite_o), .resultsrc_o(resultsrc_o), .branch_o(branch_o),
        .alucontrol_o(alucontrol_o), .rd1_o(rd1_o), .rd2_o(rd2_o), .imm_o(imm_o), .pc_o(pc_o),
        .pc4_o(pc4_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .hazard_cnt_o(hazard_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_i = 1'b0; instr_i = '0; pc_i = '0; pc4_i = '0;
        wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; flush_i = 1'b0; ex_ready_i = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", ready_o); end
        checks++; if (hazard_cnt_o !== 4'd0) begin failures++; $display("FAIL rst_hcnt got=%0h exp=0", hazard_cnt_o); end
        checks++;
        if ({regwrite_o, alusrc_o, memwrite_o, resultsrc_o, branch_o, alucontrol_o} !== 8'd0 ||
            rd1_o !== '0 || rd2_o !== '0 || imm_o !== '0 || pc_o !== '0 || pc4_o !== '0 ||
            rs1_o !== '0 || rs2_o !== '0 || rd_o !== '0) begin
            failures++; $display("FAIL rst_outputs got ctrl=%0h rd1=%0h imm=%0h pc=%0h exp=0", {regwrite_o, alusrc_o, memwrite_o, resultsrc_o, branch_o, alucontrol_o}, rd1_o, imm_o, pc_o);
        end
    endtask

    task automatic test_write_read();
        wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEADBEEF;
        tick();
        wb_we_i = 1'b0;
        valid_i = 1'b1; instr_i = I_ADDI_6_5_4; pc_i = 32'h100; pc4_i = 32'h104;
        tick();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL wr_valid got=%0h exp=1", valid_o); end
        checks++; if (rd1_o !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd1 got=%0h exp=deadbeef", rd1_o); end
        checks++; if (imm_o !== 32'd4) begin failures++; $display("FAIL wr_imm got=%0h exp=4", imm_o); end
        checks++; if ({alucontrol_o, alusrc_o, regwrite_o, memwrite_o, resultsrc_o} !== 7'b000_1_1_0_0) begin
            failures++; $display("FAIL wr_ctrl got=%b exp=0001100", {alucontrol_o, alusrc_o, regwrite_o, memwrite_o, resultsrc_o}); end
        checks++; if ({rs1_o, rd_o} !== {5'd5, 5'd6} || pc_o !== 32'h100 || pc4_o !== 32'h104) begin
            failures++; $display("FAIL wr_fields got rs1=%0d rd=%0d pc=%0h pc4=%0h exp rs1=5 rd=6 pc=100 pc4=104", rs1_o, rd_o, pc_o, pc4_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL wr_drain got=%0h exp=0", valid_o); end
    endtask

    task automatic test_load_use();
        valid_i = 1'b1; instr_i = I_LW_7_0_1;
        tick();
        checks++; if ({valid_o, resultsrc_o, rd_o} !== {1'b1, 1'b1, 5'd7}) begin
            failures++; $display("FAIL lu_lw got valid=%0h rs=%0h rd=%0d exp 1 1 7", valid_o, resultsrc_o, rd_o); end
        instr_i = I_ADD_8_7_2;
        #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL lu_ready_stall got=%0h exp=0", ready_o); end
        tick();
        checks++; if ({valid_o, regwrite_o, resultsrc_o} !== 3'b000) begin
            failures++; $display("FAIL lu_bubble got=%b exp=000", {valid_o, regwrite_o, resultsrc_o}); end
        checks++; if (hazard_cnt_o !== 4'd1) begin failures++; $display("FAIL lu_hcnt got=%0d exp=1", hazard_cnt_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL lu_ready_release got=%0h exp=1", ready_o); end
        tick();
        valid_i = 1'b0;
        checks++; if ({valid_o, rd_o, rs1_o, rs2_o, alucontrol_o} !== {1'b1, 5'd8, 5'd7, 5'd2, 3'b000}) begin
            failures++; $display("FAIL lu_add got valid=%0h rd=%0d rs1=%0d rs2=%0d alu=%0h exp 1 8 7 2 0", valid_o, rd_o, rs1_o, rs2_o, alucontrol_o); end
        checks++; if (hazard_cnt_o !== 4'd1) begin failures++; $display("FAIL lu_hcnt_after got=%0d exp=1", hazard_cnt_o); end
        tick();
    endtask

    task automatic test_backpressure_flush();
        valid_i = 1'b1; instr_i = I_SW_5_8_1;
        tick();
        held_rd1 = rd1_o;
        ex_ready_i = 1'b0; instr_i = I_ADDI_6_5_4;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0h exp=0", i, ready_o); end
            tick();
            checks++; if ({valid_o, memwrite_o, imm_o, rs2_o, rd1_o} !== {1'b1, 1'b1, 32'd8, 5'd5, held_rd1}) begin
                failures++; $display("FAIL bp_hold[%0d] got valid=%0h mw=%0h imm=%0h rs2=%0d exp 1 1 8 5", i, valid_o, memwrite_o, imm_o, rs2_o); end
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if ({valid_o, memwrite_o} !== 2'b00) begin failures++; $display("FAIL fl_bubble got=%b exp=00", {valid_o, memwrite_o}); end
        ex_ready_i = 1'b1; instr_i = I_LW_7_0_1;
        tick();
        instr_i = I_ADD_8_7_2; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        checks++; if ({valid_o, hazard_cnt_o} !== {1'b0, 4'd1}) begin
            failures++; $display("FAIL fl_no_count got valid=%0h hcnt=%0d exp 0 1", valid_o, hazard_cnt_o); end
        tick();
    endtask

    task automatic test_bypass();
        wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'h11;
        tick();
        wb_data_i = 32'h55; valid_i = 1'b1; instr_i = I_SUB_9_3_0;
        tick();
        wb_we_i = 1'b0;
`ifdef RF_BYPASS_EN
        checks++; if (rd1_o !== 32'h55) begin failures++; $display("FAIL byp_rd1 got=%0h exp=55", rd1_o); end
`else
        checks++; if (rd1_o !== 32'h11) begin failures++; $display("FAIL byp_rd1 got=%0h exp=11", rd1_o); end
`endif
        checks++; if ({alucontrol_o, rd_o, regwrite_o, alusrc_o} !== {3'b001, 5'd9, 1'b1, 1'b0}) begin
            failures++; $display("FAIL byp_sub got alu=%0h rd=%0d rw=%0h as=%0h exp 1 9 1 0", alucontrol_o, rd_o, regwrite_o, alusrc_o); end
        tick();
        valid_i = 1'b0;
        checks++; if (rd1_o !== 32'h55) begin failures++; $display("FAIL byp_later got=%0h exp=55", rd1_o); end
        tick();
    endtask

    task automatic test_edge_cases();
        valid_i = 1'b1; instr_i = I_BEQ_M8;
        tick();
        valid_i = 1'b0;
        checks++; if (imm_o !== 32'hFFFFFFF8) begin failures++; $display("FAIL beq_imm got=%0h exp=fffffff8", imm_o); end
        checks++; if ({branch_o, alucontrol_o, regwrite_o} !== {1'b1, 3'b001, 1'b0}) begin
            failures++; $display("FAIL beq_ctrl got br=%0h alu=%0h rw=%0h exp 1 1 0", branch_o, alucontrol_o, regwrite_o); end
        wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h1234;
        tick();
        wb_we_i = 1'b0; valid_i = 1'b1; instr_i = I_ADDI_10_0_0;
        tick();
        checks++; if ({valid_o, rd1_o} !== {1'b1, 32'd0}) begin failures++; $display("FAIL x0_read got valid=%0h rd1=%0h exp 1 0", valid_o, rd1_o); end
        // 43 cycles of self-dependent loads yield 21 load-use events on top of the earlier one.
        instr_i = I_LW_7_0_7;
        for (int i = 0; i < 43; i++) tick();
        checks++; if (hazard_cnt_o !== 4'hF) begin failures++; $display("FAIL hcnt_sat got=%0h exp=f", hazard_cnt_o); end
    endtask

    task automatic test_reset_mid_stall();
        ex_ready_i = 1'b0;
        tick();
        checks++; if ({valid_o, rd_o} !== {1'b1, 5'd7}) begin failures++; $display("FAIL ms_held got valid=%0h rd=%0d exp 1 7", valid_o, rd_o); end
        rst = 1'b0;
        tick();
        rst = 1'b1; valid_i = 1'b0; ex_ready_i = 1'b1;
        checks++; if ({valid_o, rd_o, resultsrc_o, hazard_cnt_o} !== {1'b0, 5'd0, 1'b0, 4'd0}) begin
            failures++; $display("FAIL ms_reset got valid=%0h rd=%0d rs=%0h hcnt=%0d exp 0 0 0 0", valid_o, rd_o, resultsrc_o, hazard_cnt_o); end
        valid_i = 1'b1; instr_i = I_SUB_9_3_0;
        tick();
        valid_i = 1'b0;
        checks++; if (rd1_o !== 32'd0) begin failures++; $display("FAIL ms_rf_clear got=%0h exp=0", rd1_o); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_load_use();
        test_backpressure_flush();
        test_bypass();
        test_edge_cases();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage_hs.md
DECODE_STAGE_HS -- requirements
Module: decode_stage_hs

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count; AW = clog2(NREG).
REQ-003 SHALL have parameter CW, default 16, meaning hazard-counter width.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 valid_i  in  1  IF presents an instruction; ready_o  out  1  stage accepts it.
REQ-007 instr_i  in  32  instruction; pc_i, pc4_i  in  XLEN  PC and PC+4.
REQ-008 wb_we_i  in  1, wb_rd_i  in  AW, wb_data_i  in  XLEN  writeback port.
REQ-009 flush_i  in  1  kill the ID/EX contents (taken branch).
REQ-010 ex_ready_i  in  1  EX accepts the ID/EX register contents.
REQ-011 valid_o  out  1  ID/EX register holds a live instruction.
REQ-012 regwrite_o, alusrc_o, memwrite_o, resultsrc_o, branch_o  out  1 each; alucontrol_o  out  3.
REQ-013 rd1_o, rd2_o, imm_o, pc_o, pc4_o  out  XLEN; rs1_o, rs2_o, rd_o  out  AW.
REQ-014 hazard_cnt_o  out  CW  count of load-use bubbles inserted.

Function
REQ-015 Decode SHALL support lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011; other opcodes decode with all control bits 0.
REQ-016 Immediates SHALL be sign-extended to XLEN: I-type for lw/I-ALU, S-type for sw, B-type for beq, 0 for R-type.
REQ-017 ALU control SHALL be: add 000, sub 001, and 010, or 011, slt 101. sub applies only to R-type with funct7[5]=1; lw/sw use add; beq uses sub.
REQ-018 Register reads of index 0 SHALL return 0, and writes to index 0 SHALL be ignored.
REQ-019 Load-use condition: valid_i, valid_o, resultsrc_o=1, rd_o!=0, and rd_o equal to instr rs1 or rs2.
REQ-020 ready_o SHALL equal (!valid_o | ex_ready_i) & !load_use & !flush_i.
REQ-021 Transfer SHALL occur when valid_i & ready_o; the ID/EX register then loads the decoded fields and valid_o=1 on the next cycle, giving 1-cycle latency.
REQ-022 If load_use and ex_ready_i, the register SHALL load a bubble next cycle (valid_o=0, all control bits 0), the instruction SHALL remain unaccepted, and hazard_cnt_o SHALL increment.
REQ-023 If !ex_ready_i and valid_o, the ID/EX register SHALL hold all outputs unchanged.
REQ-024 If valid_o=0, ex_ready_i=1 and no transfer occurs, the register SHALL become a bubble.
REQ-025 flush_i SHALL have top priority: the next cycle is a bubble regardless of ex_ready_i or load_use, and no hazard count is taken.
REQ-026 hazard_cnt_o SHALL saturate at all-ones and never wrap.

Reset
REQ-027 While rst=0 at posedge, all outputs and the register file SHALL clear to 0; ready_o SHALL follow REQ-020 with valid_o=0.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction and clear the counter.

Configuration
REQ-029 With RF_BYPASS_EN defined, a read of rs!=0 equal to wb_rd_i while wb_we_i=1 SHALL return wb_data_i in the same cycle.
REQ-030 Without RF_BYPASS_EN, such a read SHALL return the pre-write value; the write becomes visible the following cycle.

Structure
REQ-031 Opcode constants, ALU-control encodings and the ImmSrc enum SHALL reside in the shared package decode_pkg.
REQ-032 Opcode/funct decode SHALL be one combinational sub-module, decode_ctrl; the register file and the pipeline register stay in decode_stage_hs.

Verification
REQ-033 Reset test: rst=0 for 2 cycles, then release -> all outputs 0, valid_o=0, ready_o=1, hazard_cnt_o=0.
REQ-034 Write then read: write x5=0xDEADBEEF, then addi x6,x5,4 -> rd1_o=0xDEADBEEF, imm_o=4, alucontrol_o=000, alusrc_o=1, regwrite_o=1.
REQ-035 Load-use: lw x7,0(x1) followed by add x8,x7,x2 -> one bubble with valid_o=0, add appears the cycle after, hazard_cnt_o=1.
REQ-036 Backpressure and flush: ex_ready_i=0 for 3 cycles -> outputs stable and ready_o=0; flush_i=1 -> next valid_o=0 and memwrite_o=0.
REQ-037 Bypass: wb_we_i=1, wb_rd_i=3, wb_data_i=0x55 in the same cycle as sub x9,x3,x0 -> rd1_o=0x55 with RF_BYPASS_EN, old x3 value without it.
REQ-038 Edge cases: beq imm=-8 -> imm_o=0xFFFFFFF8; write to x0 -> a later read of x0 returns 0; 2^CW+5 load-use events -> counter saturates at all-ones.
